// File: rtl/eflags_unit_pkg.sv
// ---------------------------------------------------------------------------
// eflags_unit_pkg
//   Shared definitions for the RFLAGS register and the condition evaluator:
//   register width, architectural flag bit positions, x86 tttn condition
//   codes and the masks used to sanitise a flags word before it is stored.
// ---------------------------------------------------------------------------
package eflags_unit_pkg;

  localparam int REG_W = 64;

  localparam int EFLAGS_CF = 0;
  localparam int EFLAGS_PF = 2;
  localparam int EFLAGS_AF = 4;
  localparam int EFLAGS_ZF = 6;
  localparam int EFLAGS_SF = 7;
  localparam int EFLAGS_OF = 11;

  // Bit 1 of RFLAGS is reserved and always reads as 1.
  localparam logic [REG_W-1:0] EFLAGS_RESERVED_MASK = 64'h0000_0000_0000_0002;
  // Only bits 21:0 are implemented; everything above is forced to 0.
  localparam logic [REG_W-1:0] EFLAGS_IMPL_MASK     = 64'h0000_0000_003F_FFFF;

  typedef enum logic [3:0] {
    CC_O  = 4'h0, CC_NO = 4'h1, CC_B  = 4'h2, CC_AE = 4'h3,
    CC_E  = 4'h4, CC_NE = 4'h5, CC_BE = 4'h6, CC_A  = 4'h7,
    CC_S  = 4'h8, CC_NS = 4'h9, CC_P  = 4'hA, CC_NP = 4'hB,
    CC_L  = 4'hC, CC_GE = 4'hD, CC_LE = 4'hE, CC_G  = 4'hF
  } cc_e;

  function automatic logic [REG_W-1:0] eflags_sanitize(input logic [REG_W-1:0] w);
    return (w & EFLAGS_IMPL_MASK) | EFLAGS_RESERVED_MASK;
  endfunction

endpackage

// File: rtl/eflags_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// eflags_unit_cond_eval
//   Combinational x86 condition evaluator, shared with the cmov/setcc path.
//   Ports:
//     flags_i  [REG_W]  flags word to evaluate
//     cc_i     [4]      tttn condition code
//     taken_o  [1]      condition true
// ---------------------------------------------------------------------------
module eflags_unit_cond_eval
  import eflags_unit_pkg::*;
(
  input  logic [REG_W-1:0] flags_i,
  input  logic [3:0]       cc_i,
  output logic             taken_o
);

  logic cf, pf, zf, sf, of_b;
  logic base;
  logic unused_flags;

  assign cf   = flags_i[EFLAGS_CF];
  assign pf   = flags_i[EFLAGS_PF];
  assign zf   = flags_i[EFLAGS_ZF];
  assign sf   = flags_i[EFLAGS_SF];
  assign of_b = flags_i[EFLAGS_OF];

  assign unused_flags = ^flags_i;

  // cc[3:1] selects the base predicate, cc[0] inverts it.
  always_comb begin
    base = 1'b0;
    case (cc_i[3:1])
      3'd0:    base = of_b;
      3'd1:    base = cf;
      3'd2:    base = zf;
      3'd3:    base = cf | zf;
      3'd4:    base = sf;
      3'd5:    base = pf;
      3'd6:    base = sf ^ of_b;
      3'd7:    base = zf | (sf ^ of_b);
      default: base = 1'b0;
    endcase
  end

  assign taken_o = base ^ cc_i[0];

endmodule

// File: rtl/eflags_unit.sv
// ---------------------------------------------------------------------------
// eflags_unit
//   Architectural RFLAGS register plus condition query port. Captures ALU
//   eflags writes, counts in-flight flag writers, and answers Jcc/SETcc/
//   CMOVcc queries once no older writer can still change the flags.
//   Ports:
//     clk_i, rst_ni          clock, async active-low reset
//     flush_i                clears pending count and result (RFLAGS kept)
//     pend_inc_i/pend_full_o writer dispatched / counter saturated
//     wr_valid_i/wr_eflags_i ALU flags write (retires one writer)
//     q_valid_i/q_ready_o    query handshake, q_cc_i code, q_tag_i tag
//     r_valid_o/r_ready_i    result handshake, r_taken_o, r_tag_o
//     rflags_o               architectural RFLAGS
// ---------------------------------------------------------------------------
module eflags_unit
  import eflags_unit_pkg::*;
#(
  parameter int               PEND_W    = 3,
  parameter logic [REG_W-1:0] RST_FLAGS = 64'h2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             pend_inc_i,
  output logic             pend_full_o,
  input  logic             wr_valid_i,
  input  logic [REG_W-1:0] wr_eflags_i,
  input  logic             q_valid_i,
  output logic             q_ready_o,
  input  logic [3:0]       q_cc_i,
  input  logic [7:0]       q_tag_i,
  output logic             r_valid_o,
  input  logic             r_ready_i,
  output logic             r_taken_o,
  output logic [7:0]       r_tag_o,
  output logic [REG_W-1:0] rflags_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [REG_W-1:0]  rflags_q, rflags_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              r_valid_q, r_valid_d;
  logic              r_taken_q, r_taken_d;
  logic [7:0]        r_tag_q, r_tag_d;

  logic              bypass;
  logic              hazard_free;
  logic              q_accept;
  logic [REG_W-1:0]  eval_flags;
  logic              eval_taken;

  // With exactly one writer outstanding and its result arriving now, the
  // query can be answered from the ALU word instead of waiting a cycle.
  assign bypass      = (pend_q == PEND_W'(1)) && wr_valid_i;
  assign hazard_free = (pend_q == '0) || bypass;
  assign q_ready_o   = !flush_i && hazard_free && (!r_valid_q || r_ready_i);
  assign q_accept    = q_valid_i && q_ready_o;
  assign eval_flags  = bypass ? wr_eflags_i : rflags_q;

  eflags_unit_cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cc_i    (q_cc_i),
    .taken_o (eval_taken)
  );

  // Flush does not block the flags write: that writer has already executed.
  always_comb begin
    rflags_d = rflags_q;
    if (wr_valid_i) begin
      rflags_d = eflags_sanitize(wr_eflags_i);
    end
  end

  // Overflow and underflow are protocol errors; the counter saturates.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else if (pend_inc_i && !wr_valid_i) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (wr_valid_i && !pend_inc_i) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end
  end

  // Single output register; taken/tag only change on a new acceptance.
  always_comb begin
    r_valid_d = r_valid_q;
    r_taken_d = r_taken_q;
    r_tag_d   = r_tag_q;
    if (flush_i) begin
      r_valid_d = 1'b0;
    end else if (q_accept) begin
      r_valid_d = 1'b1;
      r_taken_d = eval_taken;
      r_tag_d   = q_tag_i;
    end else if (r_ready_i) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rflags_q  <= RST_FLAGS;
      pend_q    <= '0;
      r_valid_q <= 1'b0;
      r_taken_q <= 1'b0;
      r_tag_q   <= '0;
    end else begin
      rflags_q  <= rflags_d;
      pend_q    <= pend_d;
      r_valid_q <= r_valid_d;
      r_taken_q <= r_taken_d;
      r_tag_q   <= r_tag_d;
    end
  end

  assign pend_full_o = (pend_q == PEND_MAX);
  assign r_valid_o   = r_valid_q;
  assign r_taken_o   = r_taken_q;
  assign r_tag_o     = r_tag_q;
  assign rflags_o    = rflags_q;

  pend_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pend_inc_i && pend_full_o && !wr_valid_i && !flush_i));

endmodule
